avalon_block_master: RTL and testbench
======================================

Name: avalon_block_master

Overview:
Avalon-MM bus master that feeds and drains the ECCDH3DES datapath without CPU word-by-word CSR traffic. On start, it runs two phases back to back:
- Read phase: fetches num_blocks 64-bit blocks (two 32-bit words each) from system memory at src_addr and presents them on a valid/ready block stream toward the cipher core.
- Write phase: accepts num_blocks 64-bit result blocks on a second valid/ready stream and writes them to memory at dst_addr.
It is the initiator counterpart of the CSR slave and drives its master_* port group.

Parameters:
MASTER_ADDRESSWIDTH, 26, byte address width of the Avalon master port
DATAWIDTH, 32, Avalon data width (fixed at 32)
LENWIDTH, 14, width of num_blocks and the internal block counters
MAX_OUTSTANDING, 4, maximum read commands accepted but not yet returned (power of 2, ≥2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse, begins a transfer when idle
src_addr  in  MASTER_ADDRESSWIDTH  byte address of the first source word, must be 4-aligned
dst_addr  in  MASTER_ADDRESSWIDTH  byte address of the first destination word, must be 4-aligned
num_blocks  in  LENWIDTH  number of 64-bit blocks per phase
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the transfer completes
blk_out_data  out  64  block read from memory
blk_out_valid  out  1  blk_out_data valid
blk_out_ready  in  1  consumer accepts the block
blk_in_data  in  64  block to write to memory
blk_in_valid  in  1  blk_in_data valid
blk_in_ready  out  1  block accepted this cycle
master_address  out  MASTER_ADDRESSWIDTH  Avalon address
master_writedata  out  32  Avalon write data
master_write  out  1  Avalon write request
master_read  out  1  Avalon read request
master_readdata  in  32  Avalon read data
master_readdatavalid  in  1  read data return
master_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: clk is the clock; reset_n is synchronous, active-low.
- Reset values: busy, done, blk_out_valid, blk_in_ready, master_read and master_write are 0; master_address, master_writedata and blk_out_data are 0; all counters are 0; state is IDLE.
- FSM states: IDLE, RD, RD_DRAIN, WR_LO, WR_HI, FIN.
- IDLE:
  - start=1 latches src_addr, dst_addr and num_blocks, and sets busy next cycle.
  - If num_blocks=0, go to FIN (no bus traffic). Otherwise go to RD.
  - start while busy is ignored.
- RD phase, command issue:
  - Assert master_read with the current read address.
  - Hold address and read stable while master_waitrequest=1.
  - A command is accepted when master_read && !master_waitrequest. The address then advances by 4 and the issued-word counter increments.
  - Total words issued = 2*num_blocks.
- RD phase, flow control:
  - Issue is allowed only if outstanding < MAX_OUTSTANDING and (outstanding + fifo_words) < 2*MAX_OUTSTANDING.
  - The internal word FIFO has depth 2*MAX_OUTSTANDING, so it never overflows.
- RD phase, data return:
  - Every master_readdatavalid pushes master_readdata into the word FIFO and decrements outstanding.
  - If readdatavalid and command acceptance occur in the same cycle, outstanding is unchanged.
  - readdatavalid with outstanding=0 is discarded. This covers stale returns after a mid-operation reset.
- RD phase, block assembly:
  - Pairs of FIFO words form a block: first word (lower address) → [31:0], second → [63:32].
  - blk_out_valid is asserted with a full pair. Data is held stable until blk_out_ready.
  - One block transfers per cycle in which valid && ready.
- RD → RD_DRAIN once all words are issued. RD_DRAIN → WR_LO once num_blocks blocks have been handed off on blk_out.
- WR_LO:
  - blk_in_ready=1 only while no block is held. Capture blk_in_data on valid && ready.
  - Then drive master_write with [31:0] at the current write address until !master_waitrequest; address += 4; go to WR_HI.
- WR_HI:
  - Drive [63:32] the same way.
  - On acceptance, increment the written-block counter. Return to WR_LO, or go to FIN when the counter equals num_blocks.
- FIN: done=1 for exactly one cycle, busy=0 the same cycle, go to IDLE.
- Bus rules: master_read and master_write are never asserted together.
- Address arithmetic: modulo 2^MASTER_ADDRESSWIDTH; wrap past all-ones is silent.
- Counters: LENWIDTH+1 bits for word counts. num_blocks = 2^LENWIDTH−1 must complete without overflow.
- Reset mid-operation: everything returns to reset values on the next clk edge. Pending handshakes are abandoned.

Optional Feature:
BLOCK_MASTER_SWAP_EN
- Defined: the lower-address word maps to bits [63:32] in both phases. WR_LO writes [63:32] first, WR_HI writes [31:0].
- Undefined: mapping as above (lower address ↔ [31:0]).

Test Plan:
1. src=0x100, num_blocks=2, memory {0x11111111,0x22222222,0x33333333,0x44444444}, no waitrequest, blk_out_ready=1 → blk_out 0x2222222211111111 then 0x4444444433333333. Then blk_in 0xAAAA0000BBBB0000 and 0xCCCC0000DDDD0000, dst=0x200 → writes 0x200:0xBBBB0000, 0x204:0xAAAA0000, 0x208:0xDDDD0000, 0x20C:0xCCCC0000. done pulses once.
2. waitrequest high 3 cycles on every command → master_address/read/write stable throughout; same data as scenario 1.
3. Read latency 10 cycles, blk_out_ready=0 for 20 cycles, num_blocks=8 → outstanding never exceeds 4, FIFO never exceeds 8 words, no data lost, blocks in order.
4. num_blocks=0 → done one cycle after start, no master_read/master_write ever asserted.
5. Assert reset_n=0 in RD with 3 reads outstanding, release, then feed 3 stale readdatavalid → all outputs 0, data discarded; a new transfer of 1 block completes correctly.
6. start pulsed while busy → ignored; src_addr=0x3FFFFFC, num_blocks=1 → addresses 0x3FFFFFC then 0x0000000.

Source files
------------

// File: rtl/avalon_block_master_if.sv
// Avalon-MM master bus plus the two 64-bit block streams of avalon_block_master.
// The master modport is the block master's view; the slave modport is memory/cipher side.
interface avalon_block_master_if #(
   parameter int unsigned MASTER_ADDRESSWIDTH = 26
);
   logic [63:0]                    blk_out_data;
   logic                           blk_out_valid;
   logic                           blk_out_ready;
   logic [63:0]                    blk_in_data;
   logic                           blk_in_valid;
   logic                           blk_in_ready;
   logic [MASTER_ADDRESSWIDTH-1:0] master_address;
   logic [31:0]                    master_writedata;
   logic                           master_write;
   logic                           master_read;
   logic [31:0]                    master_readdata;
   logic                           master_readdatavalid;
   logic                           master_waitrequest;

   modport master (
      output blk_out_data, blk_out_valid,
      input  blk_out_ready,
      input  blk_in_data, blk_in_valid,
      output blk_in_ready,
      output master_address, master_writedata, master_write, master_read,
      input  master_readdata, master_readdatavalid, master_waitrequest
   );

   modport slave (
      input  blk_out_data, blk_out_valid,
      output blk_out_ready,
      output blk_in_data, blk_in_valid,
      input  blk_in_ready,
      input  master_address, master_writedata, master_write, master_read,
      output master_readdata, master_readdatavalid, master_waitrequest
   );
endinterface

// File: rtl/avalon_block_master.sv
// Avalon-MM block master: reads num_blocks 64-bit blocks to blk_out, then writes blk_in blocks back.
// Define BLOCK_MASTER_SWAP_EN to map the lower-address word to bits [63:32] in both phases.
module avalon_block_master #(
   parameter int unsigned MASTER_ADDRESSWIDTH = 26,
   parameter int unsigned DATAWIDTH           = 32,
   parameter int unsigned LENWIDTH            = 14,
   parameter int unsigned MAX_OUTSTANDING     = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [MASTER_ADDRESSWIDTH-1:0] src_addr,
   input  logic [MASTER_ADDRESSWIDTH-1:0] dst_addr,
   input  logic [LENWIDTH-1:0]            num_blocks,
   output logic                           busy,
   output logic                           done,
   avalon_block_master_if.master          bus
);
   localparam int unsigned AW        = MASTER_ADDRESSWIDTH;
   localparam int unsigned DW        = DATAWIDTH;
   localparam int unsigned FifoDepth = 2 * MAX_OUTSTANDING;
   localparam int unsigned PtrW      = $clog2(FifoDepth);
   localparam int unsigned CntW      = PtrW + 1;
   localparam int unsigned OutW      = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [LENWIDTH:0] One = 1;

   typedef enum logic [2:0] {StIdle, StRd, StRdDrain, StWrLo, StWrHi, StFin} state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [LENWIDTH-1:0] num_q, num_d;
   logic [LENWIDTH:0]   issued_q, issued_d, blk_cnt_q, blk_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [OutW-1:0]     outst_q, outst_d;
   logic [2*DW-1:0]     hold_q, hold_d;
   logic                held_q, held_d;

   logic [DW-1:0]       fifo_q [FifoDepth];
   logic [PtrW-1:0]     wptr_q, rptr_q;
   logic [CntW-1:0]     fcnt_q;

   logic [DW-1:0]       head0, head1, wr_first, wr_second;
   logic [2*DW-1:0]     pair;
   logic [LENWIDTH:0]   total_words;
   logic                issue_ok, rd_accept, rdv_ok, push, pop;
   logic                master_read, master_write, blk_out_valid, blk_in_ready;
   logic [DW-1:0]       master_writedata;

   assign total_words = {num_q, 1'b0};
   assign head0       = fifo_q[rptr_q];
   assign head1       = fifo_q[rptr_q + PtrW'(1)];

`ifdef BLOCK_MASTER_SWAP_EN
   assign pair      = {head0, head1};
   assign wr_first  = hold_q[2*DW-1:DW];
   assign wr_second = hold_q[DW-1:0];
`else
   assign pair      = {head1, head0};
   assign wr_first  = hold_q[DW-1:0];
   assign wr_second = hold_q[2*DW-1:DW];
`endif

   // Words return in issue order and are issued in pairs, so the FIFO head is always block-aligned.
   assign issue_ok = (state_q == StRd) && (issued_q != total_words) &&
                     (outst_q < OutW'(MAX_OUTSTANDING)) &&
                     ((CntW'(outst_q) + fcnt_q) < CntW'(FifoDepth));
   assign master_read   = issue_ok;
   assign rd_accept     = master_read && !bus.master_waitrequest;
   assign rdv_ok        = bus.master_readdatavalid && (outst_q != '0);
   assign push          = rdv_ok;
   assign blk_out_valid = ((state_q == StRd) || (state_q == StRdDrain)) &&
                          (fcnt_q >= CntW'(2)) && (blk_cnt_q != {1'b0, num_q});
   assign pop           = blk_out_valid && bus.blk_out_ready;

   assign busy = (state_q != StIdle) && (state_q != StFin);
   assign done = (state_q == StFin);

   assign bus.blk_out_valid    = blk_out_valid;
   assign bus.blk_out_data     = blk_out_valid ? pair : '0;
   assign bus.blk_in_ready     = blk_in_ready;
   assign bus.master_read      = master_read;
   assign bus.master_write     = master_write;
   assign bus.master_writedata = master_writedata;
   assign bus.master_address   = master_read  ? rd_addr_q :
                                 master_write ? wr_addr_q : '0;

   always_comb begin
      state_d          = state_q;
      rd_addr_d        = rd_addr_q;
      wr_addr_d        = wr_addr_q;
      num_d            = num_q;
      issued_d         = issued_q;
      blk_cnt_d        = blk_cnt_q;
      wr_cnt_d         = wr_cnt_q;
      outst_d          = outst_q + OutW'(rd_accept) - OutW'(rdv_ok);
      hold_d           = hold_q;
      held_d           = held_q;
      blk_in_ready     = 1'b0;
      master_write     = 1'b0;
      master_writedata = '0;

      if (pop) blk_cnt_d = blk_cnt_q + One;

      case (state_q)
         StIdle: begin
            if (start) begin
               rd_addr_d = src_addr;
               wr_addr_d = dst_addr;
               num_d     = num_blocks;
               issued_d  = '0;
               blk_cnt_d = '0;
               wr_cnt_d  = '0;
               held_d    = 1'b0;
               state_d   = (num_blocks == '0) ? StFin : StRd;
            end
         end
         StRd: begin
            if (rd_accept) begin
               rd_addr_d = rd_addr_q + AW'(4);
               issued_d  = issued_q + One;
            end
            if (issued_q == total_words) state_d = StRdDrain;
         end
         StRdDrain: begin
            if (blk_cnt_q == {1'b0, num_q}) state_d = StWrLo;
         end
         StWrLo: begin
            if (!held_q) begin
               blk_in_ready = 1'b1;
               if (bus.blk_in_valid) begin
                  hold_d = bus.blk_in_data;
                  held_d = 1'b1;
               end
            end else begin
               master_write     = 1'b1;
               master_writedata = wr_first;
               if (!bus.master_waitrequest) begin
                  wr_addr_d = wr_addr_q + AW'(4);
                  state_d   = StWrHi;
               end
            end
         end
         StWrHi: begin
            master_write     = 1'b1;
            master_writedata = wr_second;
            if (!bus.master_waitrequest) begin
               wr_addr_d = wr_addr_q + AW'(4);
               wr_cnt_d  = wr_cnt_q + One;
               held_d    = 1'b0;
               state_d   = ((wr_cnt_q + One) == {1'b0, num_q}) ? StFin : StWrLo;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         num_q     <= '0;
         issued_q  <= '0;
         blk_cnt_q <= '0;
         wr_cnt_q  <= '0;
         outst_q   <= '0;
         hold_q    <= '0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         num_q     <= num_d;
         issued_q  <= issued_d;
         blk_cnt_q <= blk_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         outst_q   <= outst_d;
         hold_q    <= hold_d;
         held_q    <= held_d;
      end
   end

   // Storage words are not reset; blk_out_data is gated by valid instead.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= bus.master_readdata;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PtrW'(1);
         if (pop)  rptr_q <= rptr_q + PtrW'(2);
         fcnt_q <= fcnt_q + CntW'(push) - CntW'(pop ? 2 : 0);
      end
   end
endmodule

// File: tb/tb_avalon_block_master.sv
// Randomized bench for avalon_block_master: a memory slave, block consumer and block
// producer run on the falling edge; expected traffic is derived from a word-addressed memory map.
module tb_avalon_block_master;
   localparam int unsigned MaxOut = 4;

   logic        clk = 1'b0;
   logic        reset_n, start, busy, done;
   logic [25:0] src_addr, dst_addr;
   logic [13:0] num_blocks;

   avalon_block_master_if #(.MASTER_ADDRESSWIDTH(26)) bus ();

   avalon_block_master dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .num_blocks (num_blocks),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, wait_cfg = 0, lat_min = 1, lat_max = 1, rdy_block_until = 0;
   bit rdy_random = 0, in_random = 0, hold_returns = 0, in_taken = 0, prev_stalled = 0;
   int accepted, returned, blocks_got, done_cnt, both_err, stab_err, max_out, max_fifo;
   int wait_left = -1, last_ret = 0;
   logic [25:0] prev_addr;
   logic        prev_rd, prev_wr;
   logic [31:0] prev_wd;
   int          rt_q[$];
   logic [31:0] rdat_q[$];
   logic [63:0] got_q[$], in_q[$], in_blocks[$];
   logic [25:0] rd_log[$], wr_alog[$];
   logic [31:0] wr_dlog[$];
   logic [31:0] mem [logic [25:0]];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [25:0] a);
      if (mem.exists(a)) return mem[a];
      return {6'h15, a} ^ 32'h9E37_79B9;
   endfunction

   // Memory slave, block consumer and block producer; inputs set here apply to the next rising edge.
   initial begin
      bus.master_waitrequest   = 1'b0;
      bus.master_readdatavalid = 1'b0;
      bus.master_readdata      = '0;
      bus.blk_out_ready        = 1'b0;
      bus.blk_in_valid         = 1'b0;
      bus.blk_in_data          = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) done_cnt++;
         bus.master_readdatavalid = 1'b0;
         bus.master_readdata      = $urandom;
         if (!hold_returns && rt_q.size() > 0 && rt_q[0] <= cyc) begin
            void'(rt_q.pop_front());
            bus.master_readdatavalid = 1'b1;
            bus.master_readdata      = rdat_q.pop_front();
            returned++;
         end
         if (bus.master_read && bus.master_write) both_err++;
         if (!reset_n) begin
            wait_left    = -1;
            prev_stalled = 0;
         end
         if (bus.master_read || bus.master_write) begin
            if (prev_stalled && (bus.master_address != prev_addr || bus.master_read != prev_rd ||
                bus.master_write != prev_wr || (prev_wr && bus.master_writedata != prev_wd)))
               stab_err++;
            if (wait_left < 0) wait_left = (wait_cfg < 0) ? int'($urandom_range(2)) : wait_cfg;
            if (wait_left > 0) begin
               bus.master_waitrequest = 1'b1;
               wait_left--;
               prev_stalled = 1;
               prev_addr = bus.master_address;
               prev_rd   = bus.master_read;
               prev_wr   = bus.master_write;
               prev_wd   = bus.master_writedata;
            end else begin
               bus.master_waitrequest = 1'b0;
               prev_stalled = 0;
               wait_left    = -1;
               if (reset_n && bus.master_read) begin
                  int t;
                  t = cyc + int'($urandom_range(lat_max, lat_min));
                  if (t <= last_ret) t = last_ret + 1;
                  last_ret = t;
                  rt_q.push_back(t);
                  rdat_q.push_back(mem_word(bus.master_address));
                  rd_log.push_back(bus.master_address);
                  accepted++;
               end else if (reset_n) begin
                  wr_alog.push_back(bus.master_address);
                  wr_dlog.push_back(bus.master_writedata);
               end
            end
         end else begin
            if (prev_stalled) stab_err++;
            prev_stalled = 0;
            bus.master_waitrequest = 1'b0;
         end
         bus.blk_out_ready = (cyc < rdy_block_until) ? 1'b0 :
                             (rdy_random ? ($urandom_range(3) != 0) : 1'b1);
         if (bus.blk_out_valid && bus.blk_out_ready) begin
            got_q.push_back(bus.blk_out_data);
            blocks_got++;
         end
         if (in_q.size() == 0) bus.blk_in_valid = 1'b0;
         else if (in_taken || !bus.blk_in_valid)
            bus.blk_in_valid = !in_random || ($urandom_range(1) == 1);
         bus.blk_in_data = bus.blk_in_valid ? in_q[0] : {$urandom, $urandom};
         in_taken = 0;
         if (bus.blk_in_valid && bus.blk_in_ready) begin
            void'(in_q.pop_front());
            in_taken = 1;
         end
         if (accepted - returned > max_out) max_out = accepted - returned;
         if (returned - 2 * blocks_got > max_fifo) max_fifo = returned - 2 * blocks_got;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_out_valid"}, bus.blk_out_valid, 0);
      check({tag, "_in_ready"}, bus.blk_in_ready, 0);
      check({tag, "_read"}, bus.master_read, 0);
      check({tag, "_write"}, bus.master_write, 0);
      check({tag, "_address"}, bus.master_address, 0);
      check({tag, "_writedata"}, bus.master_writedata, 0);
      check({tag, "_out_data"}, bus.blk_out_data, 0);
   endtask

   task automatic run_xfer(input string tag, input logic [25:0] src, input logic [25:0] dst,
                           input int num, input int wcfg, input int lmin, input int lmax,
                           input int rblock, input bit rrand, input bit irand, input bit poke);
      logic [63:0] exp_blk[$];
      logic [31:0] w0, w1;
      logic [25:0] a;
      int c;
      exp_blk = {};
      for (int k = 0; k < num; k++) begin
         w0 = mem_word(src + 26'(8 * k));
         w1 = mem_word(src + 26'(8 * k + 4));
`ifdef BLOCK_MASTER_SWAP_EN
         exp_blk.push_back({w0, w1});
`else
         exp_blk.push_back({w1, w0});
`endif
      end
      while (in_blocks.size() < num) in_blocks.push_back({$urandom, $urandom});
      @(posedge clk); #1;
      wait_cfg = wcfg; lat_min = lmin; lat_max = lmax; rdy_random = rrand; in_random = irand;
      accepted = 0; returned = 0; blocks_got = 0; done_cnt = 0;
      both_err = 0; stab_err = 0; max_out = 0; max_fifo = 0;
      got_q = {}; rd_log = {}; wr_alog = {}; wr_dlog = {};
      in_q = in_blocks;
      rdy_block_until = cyc + rblock;
      src_addr = src; dst_addr = dst; num_blocks = 14'(num); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (num == 0) begin
         @(negedge clk);
         check({tag, "_done_next_cycle"}, done, 1);
      end
      if (poke) begin
         repeat (2) @(posedge clk);
         #1 check({tag, "_busy"}, busy, 1);
         src_addr = 26'h0; dst_addr = 26'h40; num_blocks = 14'd5; start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      c = 0;
      while (done_cnt == 0 && c < 5000) begin
         @(negedge clk);
         c++;
      end
      if (done_cnt == 0) begin
         check({tag, "_timeout"}, 0, 1);
         do_reset();
      end
      repeat (8) @(negedge clk);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_both_rw"}, both_err, 0);
      check({tag, "_stable"}, stab_err, 0);
      check({tag, "_max_outstanding_ok"}, max_out <= MaxOut, 1);
      check({tag, "_max_fifo_ok"}, max_fifo <= 2 * MaxOut, 1);
      check({tag, "_nblocks_out"}, got_q.size(), num);
      for (int k = 0; k < num && k < got_q.size(); k++)
         check($sformatf("%s_blk%0d", tag, k), got_q[k], exp_blk[k]);
      check({tag, "_nreads"}, rd_log.size(), 2 * num);
      for (int i = 0; i < 2 * num && i < rd_log.size(); i++) begin
         a = src + 26'(4 * i);
         check($sformatf("%s_rdaddr%0d", tag, i), rd_log[i], a);
      end
      check({tag, "_nwrites"}, wr_alog.size(), 2 * num);
      for (int i = 0; i < 2 * num && i < wr_alog.size(); i++) begin
         a = dst + 26'(4 * i);
`ifdef BLOCK_MASTER_SWAP_EN
         w0 = (i % 2 == 0) ? in_blocks[i / 2][63:32] : in_blocks[i / 2][31:0];
`else
         w0 = (i % 2 == 0) ? in_blocks[i / 2][31:0] : in_blocks[i / 2][63:32];
`endif
         check($sformatf("%s_wraddr%0d", tag, i), wr_alog[i], a);
         check($sformatf("%s_wrdata%0d", tag, i), wr_dlog[i], w0);
      end
      in_blocks = {};
   endtask

   initial begin
      int c;
      reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; num_blocks = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");

      mem[26'h100] = 32'h1111_1111; mem[26'h104] = 32'h2222_2222;
      mem[26'h108] = 32'h3333_3333; mem[26'h10C] = 32'h4444_4444;
      in_blocks = {64'hAAAA_0000_BBBB_0000, 64'hCCCC_0000_DDDD_0000};
      run_xfer("basic", 26'h100, 26'h200, 2, 0, 1, 1, 0, 0, 0, 0);
      in_blocks = {64'hAAAA_0000_BBBB_0000, 64'hCCCC_0000_DDDD_0000};
      run_xfer("waitreq", 26'h100, 26'h200, 2, 3, 1, 1, 0, 0, 0, 0);
      run_xfer("backpressure", 26'h1000, 26'h2000, 8, 0, 10, 10, 20, 0, 0, 0);
      run_xfer("zero", 26'h300, 26'h400, 0, 0, 1, 1, 0, 0, 0, 0);

      // Reset while reads are in flight, then replay their returns into an idle master.
      hold_returns = 1;
      wait_cfg = 0; lat_min = 10; lat_max = 10; rdy_random = 0;
      @(posedge clk); #1;
      src_addr = 26'h5000; dst_addr = 26'h6000; num_blocks = 14'd4; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      c = 0;
      while (accepted - returned < 3 && c < 200) begin
         @(posedge clk);
         c++;
      end
      check("midreset_reads_in_flight", accepted - returned >= 3, 1);
      #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check_reset_vals("midreset");
      got_q = {};
      hold_returns = 0;
      repeat (30) @(negedge clk);
      check("stale_blocks", got_q.size(), 0);
      check("stale_busy", busy, 0);
      check("stale_out_valid", bus.blk_out_valid, 0);
      run_xfer("after_reset", 26'h7000, 26'h7100, 1, 0, 2, 4, 0, 0, 0, 0);

      run_xfer("wrap_poke", 26'h3FF_FFFC, 26'h3FF_FFF8, 1, 1, 1, 3, 0, 0, 0, 1);

      for (int r = 0; r < 3; r++) begin
         logic [25:0] s, d;
         s = 26'($urandom) & ~26'h3;
         d = 26'($urandom) & ~26'h3;
         run_xfer($sformatf("rand%0d", r), s, d, int'($urandom_range(6, 1)), -1, 1, 6, 0,
                  1, 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end
endmodule
